// File: rtl/note_phrase_classifier.sv
// note_phrase_classifier: matches a phrase of SEQ_LEN notes against N_CLASS
// reference patterns in parallel. It reports the winning class on tipo and on a
// 7-segment digit, or it reports an error. All outputs are registered.
module note_phrase_classifier #(
   parameter int SEQ_LEN = 5,
   parameter int N_CLASS = 3,
   parameter int TIMEOUT = 0,
   parameter logic [N_CLASS*SEQ_LEN*4-1:0] PATTERNS = '0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ok,
   input  logic       tom,
   input  logic [2:0] nota,
   output logic       fim,
   output logic       err,
   output logic       busy,
   output logic [2:0] tipo,
   output logic [6:0] display
);

   localparam int PW = $clog2(SEQ_LEN);
   localparam int TW = $clog2(TIMEOUT + 2);
   localparam logic [PW-1:0] LAST_POS  = PW'(SEQ_LEN - 1);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DONE    = 2'd2,
      ST_ERROR   = 2'd3
   } state_t;

   // A pattern entry with nota 000 accepts any valid note, whatever its tone.
   function automatic logic match_entry(input logic [3:0] ent, input logic t, input logic [2:0] n);
      return ((ent[2:0] == 3'b000) && (n != 3'b000)) || ({t, n} == ent);
   endfunction

   // Active-high segments {g,f,e,d,c,b,a} for class digits 1..7.
   function automatic logic [6:0] seg_digit(input logic [2:0] d);
      logic [6:0] s;
      case (d)
         3'd1:    s = 7'b0000110;
         3'd2:    s = 7'b1011011;
         3'd3:    s = 7'b1001111;
         3'd4:    s = 7'b1100110;
         3'd5:    s = 7'b1101101;
         3'd6:    s = 7'b1111101;
         3'd7:    s = 7'b0000111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   state_t             state_r, state_n;
   logic [PW-1:0]      pos_r, pos_n;
   logic [N_CLASS-1:0] alive_r, alive_n;
   logic [TW-1:0]      timer_r, timer_n;
   logic [2:0]         tipo_r, tipo_n;
   logic               fim_r, err_r, busy_r;
   logic               fim_n, err_n, busy_n;
   logic [6:0]         display_r, display_n;

   logic               start_s;
   logic [PW-1:0]      eval_pos_s;
   logic [N_CLASS-1:0] match_s;
   logic [N_CLASS-1:0] alive_eval_s;
   logic [2:0]         win_s;

   // Match the incoming note against every class at the current position; pick the lowest survivor.
   always_comb begin
      start_s    = ok && (state_r != ST_COLLECT);
      eval_pos_s = start_s ? {PW{1'b0}} : pos_r;
      for (int c = 0; c < N_CLASS; c++) begin
         match_s[c] = match_entry(PATTERNS[(c*SEQ_LEN + int'(eval_pos_s))*4 +: 4], tom, nota);
      end
      alive_eval_s = (start_s ? {N_CLASS{1'b1}} : alive_r) & match_s;
      win_s = 3'd0;
      for (int c = N_CLASS - 1; c >= 0; c--) begin
         win_s = alive_eval_s[c] ? 3'(c + 1) : win_s;
      end
   end

   // Next-state logic: note evaluation, inter-note timeout and auto-restart from DONE/ERROR.
   always_comb begin
      state_n = state_r;
      pos_n   = pos_r;
      alive_n = alive_r;
      timer_n = timer_r;
      tipo_n  = tipo_r;
      if (ok) begin
         timer_n = {TW{1'b0}};
         if ((nota == 3'b000) || (alive_eval_s == {N_CLASS{1'b0}})) begin
            state_n = ST_ERROR;
            pos_n   = {PW{1'b0}};
            alive_n = {N_CLASS{1'b1}};
            tipo_n  = 3'd0;
         end else if (eval_pos_s == LAST_POS) begin
            state_n = ST_DONE;
            pos_n   = {PW{1'b0}};
            alive_n = {N_CLASS{1'b1}};
            tipo_n  = win_s;
         end else begin
            state_n = ST_COLLECT;
            pos_n   = eval_pos_s + 1'b1;
            alive_n = alive_eval_s;
            tipo_n  = 3'd0;
         end
      end else if (state_r == ST_COLLECT) begin
         timer_n = timer_r + 1'b1;
         if ((TIMEOUT != 0) && (timer_n == TIMEOUT_V)) begin
            state_n = ST_ERROR;
            pos_n   = {PW{1'b0}};
            alive_n = {N_CLASS{1'b1}};
            timer_n = {TW{1'b0}};
            tipo_n  = 3'd0;
         end else begin
            state_n = ST_COLLECT;
         end
      end else begin
         state_n = state_r;
      end
   end

   // Output decode from the next state, so outputs are registered with no extra latency.
   always_comb begin
      fim_n     = 1'b0;
      err_n     = 1'b0;
      busy_n    = 1'b0;
      display_n = 7'b0000000;
      case (state_n)
         ST_IDLE: begin
            display_n = 7'b0000000;
         end
         ST_COLLECT: begin
            busy_n    = 1'b1;
            display_n = 7'b1000000;
         end
         ST_DONE: begin
            fim_n     = 1'b1;
            display_n = seg_digit(tipo_n);
         end
         ST_ERROR: begin
            fim_n     = 1'b1;
            err_n     = 1'b1;
            display_n = 7'b1111001;
         end
         default: begin
            display_n = 7'b0000000;
         end
      endcase
   end

   // State, phrase tracking and output registers; reset aborts any phrase in progress.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         pos_r     <= {PW{1'b0}};
         alive_r   <= {N_CLASS{1'b1}};
         timer_r   <= {TW{1'b0}};
         tipo_r    <= 3'd0;
         fim_r     <= 1'b0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
         display_r <= 7'b0000000;
      end else begin
         state_r   <= state_n;
         pos_r     <= pos_n;
         alive_r   <= alive_n;
         timer_r   <= timer_n;
         tipo_r    <= tipo_n;
         fim_r     <= fim_n;
         err_r     <= err_n;
         busy_r    <= busy_n;
         display_r <= display_n;
      end
   end

   assign fim     = fim_r;
   assign err     = err_r;
   assign busy    = busy_r;
   assign tipo    = tipo_r;
   assign display = display_r;

endmodule

// File: tb/tb_note_phrase_classifier.sv
// Testbench for note_phrase_classifier: a table of directed vectors, hand-written
// timeout and reset sequences, then random notes checked against a phrase-level model.
module tb_note_phrase_classifier;

   localparam int SEQ_LEN = 3;
   localparam int N_CLASS = 2;
   localparam int TIMEOUT = 4;
   // class0 = {1,do}{1,re}{1,mi}; class1 = {0,la}{wild}{0,si}; entry (c,p) at [(c*3+p)*4 +: 4]
   localparam logic [23:0] PATTERNS = {4'b0111, 4'b0000, 4'b0110, 4'b1011, 4'b1010, 4'b1001};

   // Packed view {fim,err,busy,tipo[2:0],display[6:0]}
   localparam logic [12:0] O_IDLE = {1'b0, 1'b0, 1'b0, 3'd0, 7'b0000000};
   localparam logic [12:0] O_COL  = {1'b0, 1'b0, 1'b1, 3'd0, 7'b1000000};
   localparam logic [12:0] O_D1   = {1'b1, 1'b0, 1'b0, 3'd1, 7'b0000110};
   localparam logic [12:0] O_D2   = {1'b1, 1'b0, 1'b0, 3'd2, 7'b1011011};
   localparam logic [12:0] O_ERR  = {1'b1, 1'b1, 1'b0, 3'd0, 7'b1111001};

   logic       clk = 1'b0;
   logic       reset;
   logic       ok;
   logic       tom;
   logic [2:0] nota;
   logic       fim, err, busy;
   logic [2:0] tipo;
   logic [6:0] display;

   int checks   = 0;
   int failures = 0;

   note_phrase_classifier #(
      .SEQ_LEN (SEQ_LEN),
      .N_CLASS (N_CLASS),
      .TIMEOUT (TIMEOUT),
      .PATTERNS(PATTERNS)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .ok     (ok),
      .tom    (tom),
      .nota   (nota),
      .fim    (fim),
      .err    (err),
      .busy   (busy),
      .tipo   (tipo),
      .display(display)
   );

   always #5 clk = ~clk;

   // ---------------- phrase-level reference model ----------------
   logic [3:0] pat [N_CLASS][SEQ_LEN];
   logic [6:0] digits [8];
   int         m_phase;          // 0 idle, 1 collecting, 2 done, 3 error
   logic [3:0] m_q [$];          // notes of the phrase in progress
   int         m_idle;
   int         m_cls;

   function automatic logic m_match(input logic [3:0] ent, input logic [3:0] note);
      return ((ent[2:0] == 3'b000) && (note[2:0] != 3'b000)) || (ent == note);
   endfunction

   task automatic model_reset();
      m_phase = 0;
      m_q.delete();
      m_idle = 0;
      m_cls = 0;
   endtask

   task automatic model_step(input logic o, input logic [3:0] note);
      int found;
      bit all_ok;
      if (o) begin
         if (m_phase != 1) m_q.delete();
         m_q.push_back(note);
         m_idle = 0;
         if (note[2:0] == 3'b000) begin
            m_phase = 3;
         end else begin
            found = -1;
            for (int c = N_CLASS - 1; c >= 0; c--) begin
               all_ok = 1'b1;
               for (int i = 0; i < m_q.size(); i++)
                  if (!m_match(pat[c][i], m_q[i])) all_ok = 1'b0;
               if (all_ok) found = c;
            end
            if (found < 0) m_phase = 3;
            else if (m_q.size() == SEQ_LEN) begin
               m_phase = 2;
               m_cls = found + 1;
            end else m_phase = 1;
         end
      end else if (m_phase == 1) begin
         m_idle++;
         if (m_idle == TIMEOUT) m_phase = 3;
      end
   endtask

   function automatic logic [12:0] model_expect();
      case (m_phase)
         1:       return O_COL;
         2:       return {1'b1, 1'b0, 1'b0, 3'(m_cls), digits[m_cls]};
         3:       return O_ERR;
         default: return O_IDLE;
      endcase
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string nm, input logic [12:0] exp);
      logic [12:0] got;
      got = {fim, err, busy, tipo, display};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got {fim,err,busy,tipo,display}=%b required %b", nm, got, exp);
      end
   endtask

   // Drive one cycle of inputs (called #1 after a rising edge), advance model, sample #1 after the edge.
   task automatic tick(input logic o, input logic t, input logic [2:0] n);
      ok = o; tom = t; nota = n;
      @(posedge clk);
      model_step(o, {t, n});
      #1;
   endtask

   task automatic tick_chk(input logic o, input logic t, input logic [2:0] n,
                           input logic [12:0] exp, input string nm);
      tick(o, t, n);
      check(nm, exp);
   endtask

   task automatic pulse_reset(input string nm);
      ok = 1'b0; tom = 1'b0; nota = 3'd0;
      reset = 1'b1;
      #2;
      check(nm, O_IDLE);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   typedef struct {
      logic        ok;
      logic        tom;
      logic [2:0]  nota;
      logic [12:0] exp;
   } vec_t;

   vec_t tbl [$];

   function automatic void add(input logic o, input logic t, input logic [2:0] n, input logic [12:0] e);
      vec_t v;
      v.ok = o; v.tom = t; v.nota = n; v.exp = e;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [3:0] cand;
      int idx;
      pat[0][0] = 4'b1001; pat[0][1] = 4'b1010; pat[0][2] = 4'b1011;
      pat[1][0] = 4'b0110; pat[1][1] = 4'b0000; pat[1][2] = 4'b0111;
      digits[0] = 7'b0000000; digits[1] = 7'b0000110; digits[2] = 7'b1011011;
      digits[3] = 7'b1001111; digits[4] = 7'b1100110; digits[5] = 7'b1101101;
      digits[6] = 7'b1111101; digits[7] = 7'b0000111;
      model_reset();

      // Directed vectors, starting from IDLE
      add(1'b1, 1'b1, 3'd1, O_COL);  add(1'b1, 1'b1, 3'd2, O_COL);  add(1'b1, 1'b1, 3'd3, O_D1);
      add(1'b0, 1'b0, 3'd0, O_D1);   add(1'b0, 1'b1, 3'd5, O_D1);   // DONE holds, no timeout
      add(1'b1, 1'b0, 3'd6, O_COL);  add(1'b1, 1'b1, 3'd4, O_COL);  add(1'b1, 1'b0, 3'd7, O_D2);
      add(1'b1, 1'b1, 3'd1, O_COL);  add(1'b1, 1'b1, 3'd5, O_ERR);
      add(1'b0, 1'b0, 3'd0, O_ERR);  add(1'b1, 1'b1, 3'd0, O_ERR);  // invalid note at position 0
      add(1'b1, 1'b1, 3'd1, O_COL);  add(1'b0, 1'b0, 3'd0, O_COL);  add(1'b1, 1'b0, 3'd0, O_ERR);
      add(1'b1, 1'b1, 3'd1, O_COL);  add(1'b1, 1'b1, 3'd2, O_COL);  add(1'b1, 1'b0, 3'd0, O_ERR);
      add(1'b1, 1'b0, 3'd6, O_COL);  add(1'b1, 1'b1, 3'd2, O_COL);  add(1'b1, 1'b1, 3'd7, O_ERR);

      reset = 1'b1; ok = 1'b0; tom = 1'b0; nota = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", O_IDLE);
      reset = 1'b0;
      tick_chk(1'b0, 1'b0, 3'd0, O_IDLE, "idle_hold");

      for (int i = 0; i < tbl.size(); i++)
         tick_chk(tbl[i].ok, tbl[i].tom, tbl[i].nota, tbl[i].exp, $sformatf("vec%0d", i));

      // Timeout: four idle cycles after the first note give ERROR on the fourth
      tick_chk(1'b1, 1'b1, 3'd1, O_COL, "to_start");
      for (int i = 0; i < 3; i++) tick_chk(1'b0, 1'b0, 3'd0, O_COL, $sformatf("to_idle%0d", i));
      tick_chk(1'b0, 1'b0, 3'd0, O_ERR, "to_expire");
      // Three idle cycles only, then the phrase completes
      tick_chk(1'b1, 1'b1, 3'd1, O_COL, "nto_start");
      for (int i = 0; i < 3; i++) tick_chk(1'b0, 1'b0, 3'd0, O_COL, $sformatf("nto_idle%0d", i));
      tick_chk(1'b1, 1'b1, 3'd2, O_COL, "nto_n2");
      for (int i = 0; i < 3; i++) tick_chk(1'b0, 1'b0, 3'd0, O_COL, $sformatf("nto2_idle%0d", i));
      tick_chk(1'b1, 1'b1, 3'd3, O_D1, "nto_done");

      // Reset between notes 2 and 3, then a fresh phrase
      tick_chk(1'b1, 1'b1, 3'd1, O_COL, "rst_n1");
      tick_chk(1'b1, 1'b1, 3'd2, O_COL, "rst_n2");
      pulse_reset("rst_mid");
      tick_chk(1'b0, 1'b0, 3'd0, O_IDLE, "rst_idle");
      tick_chk(1'b1, 1'b1, 3'd1, O_COL, "fresh_n1");
      tick_chk(1'b1, 1'b1, 3'd2, O_COL, "fresh_n2");
      tick_chk(1'b1, 1'b1, 3'd3, O_D1, "fresh_done");

      // Random notes, biased toward pattern entries, against the model
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 99) == 0) begin
            pulse_reset("rand_reset");
         end else begin
            idx = $urandom_range(0, N_CLASS*SEQ_LEN - 1);
            cand = pat[idx / SEQ_LEN][idx % SEQ_LEN];
            if (cand[2:0] == 3'b000) cand = {1'($urandom_range(0, 1)), 3'($urandom_range(1, 7))};
            if ($urandom_range(0, 2) == 0) cand = 4'($urandom_range(0, 15));
            tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, cand[3], cand[2:0]);
            check($sformatf("rand%0d", k), model_expect());
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
